// File: rtl/gpu_pkg.sv
// Shared GPU definitions: fetch-arbiter FSM state encoding.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAITING  = 2'd1,
        RELAYING = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts one past the last
// winner and wraps modulo NUM_CONSUMERS; the first requester found wins.
module rr_arbiter
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int IDX_BITS      = $clog2(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] i_request,
    input  logic [IDX_BITS-1:0]      i_last_grant,
    output logic                     o_grant_valid,
    output logic [IDX_BITS-1:0]      o_grant_index
);

    // Walk the rotated priority order and keep the first requesting index.
    always_comb begin
        int   w_cand;
        logic w_hit;
        w_cand        = 0;
        w_hit         = 1'b0;
        o_grant_valid = 1'b0;
        o_grant_index = {IDX_BITS{1'b0}};
        for (int k = 1; k <= NUM_CONSUMERS; k++) begin
            w_cand        = (int'(i_last_grant) + k) % NUM_CONSUMERS;
            w_hit         = ~o_grant_valid & i_request[w_cand];
            o_grant_index = w_hit ? IDX_BITS'(w_cand) : o_grant_index;
            o_grant_valid = o_grant_valid | w_hit;
        end
    end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Program-memory arbiter: several instruction fetchers share one memory
// read port. One read is in flight at a time; winners are chosen
// round-robin, and each result is relayed until its fetcher drops valid.
// Optional feature macro: PROG_MEM_TIMEOUT_EN -- bounds the memory wait to
// TIMEOUT_CYCLES, answering with a NOP (all-zero) word and a sticky
// timeout_error flag when the memory never responds.
module prog_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_CONSUMERS  = 4,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    output logic                                    mem_read_valid,
    output logic [ADDR_BITS-1:0]                    mem_read_address,
    input  logic                                    mem_read_ready,
    input  logic [DATA_BITS-1:0]                    mem_read_data,
    output logic                                    timeout_error
);

    localparam int IDX_BITS = $clog2(NUM_CONSUMERS);

    // Reject configurations outside the supported range at elaboration.
    if (NUM_CONSUMERS < 2 || NUM_CONSUMERS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("prog_mem_arbiter: unsupported parameter value");
    end

    fetch_state_t                            r_state;
    fetch_state_t                            w_state_next;
    logic [IDX_BITS-1:0]                     r_grant;
    logic [IDX_BITS-1:0]                     w_grant_next;
    logic [IDX_BITS-1:0]                     r_last_grant;
    logic [IDX_BITS-1:0]                     w_last_grant_next;
    logic                                    r_mem_valid;
    logic                                    w_mem_valid_next;
    logic [ADDR_BITS-1:0]                    r_mem_addr;
    logic [ADDR_BITS-1:0]                    w_mem_addr_next;
    logic [NUM_CONSUMERS-1:0]                r_ready;
    logic [NUM_CONSUMERS-1:0]                w_ready_next;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_data;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] w_data_next;
    logic                                    w_arb_valid;
    logic [IDX_BITS-1:0]                     w_arb_index;

`ifdef PROG_MEM_TIMEOUT_EN
    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_BITS-1:0] r_wait_cnt;
    logic [CNT_BITS-1:0] w_wait_cnt_next;
    logic                r_timeout;
    logic                w_timeout_next;
`endif

    rr_arbiter #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .IDX_BITS      (IDX_BITS)
    ) u_rr_arbiter (
        .i_request     (consumer_read_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_arb_valid),
        .o_grant_index (w_arb_index)
    );

    // Next-state and next-output decisions for the fetch FSM.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        w_mem_valid_next  = r_mem_valid;
        w_mem_addr_next   = r_mem_addr;
        w_ready_next      = r_ready;
        w_data_next       = r_data;
`ifdef PROG_MEM_TIMEOUT_EN
        w_wait_cnt_next   = r_wait_cnt;
        w_timeout_next    = r_timeout;
`endif
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_grant_next      = w_arb_index;
                    w_last_grant_next = w_arb_index;
                    w_mem_valid_next  = 1'b1;
                    w_mem_addr_next   = consumer_read_address[w_arb_index];
                    w_state_next      = WAITING;
`ifdef PROG_MEM_TIMEOUT_EN
                    w_wait_cnt_next   = {CNT_BITS{1'b0}};
`endif
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAITING: begin
                if (mem_read_ready) begin
                    w_mem_valid_next      = 1'b0;
                    w_ready_next[r_grant] = 1'b1;
                    w_data_next[r_grant]  = mem_read_data;
                    w_state_next          = RELAYING;
                end else begin
`ifdef PROG_MEM_TIMEOUT_EN
                    // The last silent cycle of the budget answers with a NOP.
                    if (r_wait_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
                        w_mem_valid_next      = 1'b0;
                        w_ready_next[r_grant] = 1'b1;
                        w_data_next[r_grant]  = {DATA_BITS{1'b0}};
                        w_timeout_next        = 1'b1;
                        w_state_next          = RELAYING;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt + CNT_BITS'(1);
                    end
`else
                    w_state_next = WAITING;
`endif
                end
            end
            RELAYING: begin
                // A fetcher that already dropped valid sees a one-cycle pulse.
                if (!consumer_read_valid[r_grant]) begin
                    w_ready_next[r_grant] = 1'b0;
                    w_state_next          = IDLE;
                end else begin
                    w_state_next = RELAYING;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_mem_valid_next = 1'b0;
                w_ready_next     = {NUM_CONSUMERS{1'b0}};
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= {IDX_BITS{1'b0}};
            r_last_grant <= IDX_BITS'(NUM_CONSUMERS - 1);
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= {ADDR_BITS{1'b0}};
            r_ready      <= {NUM_CONSUMERS{1'b0}};
            r_data       <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
`ifdef PROG_MEM_TIMEOUT_EN
            r_wait_cnt   <= {CNT_BITS{1'b0}};
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_mem_valid  <= w_mem_valid_next;
            r_mem_addr   <= w_mem_addr_next;
            r_ready      <= w_ready_next;
            r_data       <= w_data_next;
`ifdef PROG_MEM_TIMEOUT_EN
            r_wait_cnt   <= w_wait_cnt_next;
            r_timeout    <= w_timeout_next;
`endif
        end
    end

    assign consumer_read_ready = r_ready;
    assign consumer_read_data  = r_data;
    assign mem_read_valid      = r_mem_valid;
    assign mem_read_address    = r_mem_addr;
`ifdef PROG_MEM_TIMEOUT_EN
    assign timeout_error       = r_timeout;
`else
    assign timeout_error       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Self-checking bench for prog_mem_arbiter: directed scenarios followed by
// randomized fetch traffic, checked against a transaction-level model.
module tb_prog_mem_arbiter;

    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NC-1:0]         valid;
    logic [NC-1:0][AB-1:0] addr;
    logic [NC-1:0]         rdy;
    logic [NC-1:0][DB-1:0] rdata;
    logic                  mvalid;
    logic [AB-1:0]         maddr;
    logic                  mready;
    logic [DB-1:0]         mdata;
    logic                  terr;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state: last winner and the word each fetcher last received.
    int          m_last;
    logic [DB-1:0] m_data [NC];

    prog_mem_arbiter #(
        .NUM_CONSUMERS  (NC),
        .ADDR_BITS      (AB),
        .DATA_BITS      (DB),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (valid),
        .consumer_read_address (addr),
        .consumer_read_ready   (rdy),
        .consumer_read_data    (rdata),
        .mem_read_valid        (mvalid),
        .mem_read_address      (maddr),
        .mem_read_ready        (mready),
        .mem_read_data         (mdata),
        .timeout_error         (terr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int rr_pick(input logic [NC-1:0] req, input int last);
        for (int k = 1; k <= NC; k++) begin
            if (req[(last + k) % NC]) return (last + k) % NC;
        end
        return -1;
    endfunction

    task automatic check_all_data(input string tag);
        for (int j = 0; j < NC; j++) check_eq(tag, rdata[j], m_data[j]);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        valid  = '0;
        mready = 1'b0;
        mdata  = '0;
        tick();
        tick();
        reset  = 1'b0;
        m_last = NC - 1;
        for (int j = 0; j < NC; j++) m_data[j] = '0;
    endtask

    // One complete fetch: grant, lat silent cycles, response, relay, release.
    task automatic run_txn(input int lat, input logic [DB-1:0] word, input int hold,
                           input bit drop_early, input bit add_reqs, output int got);
        int w;
        w = rr_pick(valid, m_last);
        if (w < 0) begin
            addr[0]  = 8'h00;
            valid[0] = 1'b1;
            w        = 0;
        end
        tick();
        check_eq("grant_mvalid", mvalid, 1);
        check_eq("grant_addr", maddr, addr[w]);
        check_eq("grant_rdy", rdy, 0);
        if (drop_early) valid[w] = 1'b0;
        for (int c = 0; c < lat; c++) begin
            if (add_reqs) begin
                for (int j = 0; j < NC; j++) begin
                    if (j != w && !valid[j] && $urandom_range(0, 2) == 0) begin
                        addr[j]  = AB'($urandom);
                        valid[j] = 1'b1;
                    end
                end
            end
            tick();
            check_eq("wait_mvalid", mvalid, 1);
            check_eq("wait_rdy", rdy, 0);
        end
        mready = 1'b1;
        mdata  = word;
        tick();
        mready = 1'b0;
        mdata  = DB'($urandom);
        m_data[w] = word;
        got = -1;
        for (int j = 0; j < NC; j++) if (rdy[j]) got = j;
        check_eq("resp_rdy", rdy, 32'(1) << w);
        check_eq("resp_mvalid", mvalid, 0);
        check_all_data("resp_data");
        if (!drop_early) begin
            for (int h = 0; h < hold; h++) begin
                mready = 1'($urandom_range(0, 1));
                tick();
                check_eq("hold_rdy", rdy, 32'(1) << w);
                check_eq("hold_data", rdata[w], m_data[w]);
            end
            mready   = 1'b0;
            valid[w] = 1'b0;
        end
        tick();
        check_eq("release_rdy", rdy, 0);
        check_eq("release_mvalid", mvalid, 0);
        check_eq("timeout_flag", terr, 0);
        m_last = w;
    endtask

    initial begin
        int got;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        addr  = '0;

        // Reset state.
        do_reset();
        check_eq("rst_rdy", rdy, 0);
        check_eq("rst_mvalid", mvalid, 0);
        check_eq("rst_maddr", maddr, 0);
        check_eq("rst_terr", terr, 0);
        check_all_data("rst_data");
        tick();
        check_eq("idle_no_req", mvalid, 0);

        // Single fetch from consumer 0, address 0x05, data 0x1234.
        addr[0]  = 8'h05;
        valid[0] = 1'b1;
        run_txn(2, 16'h1234, 1, 1'b0, 1'b0, got);
        check_eq("first_winner", got, 0);

        // After consumer 0 won, only 2 and 3 request: 2 then 3.
        addr[2] = 8'hA2;
        addr[3] = 8'hA3;
        valid   = 4'b1100;
        run_txn(1, 16'h2222, 0, 1'b0, 1'b0, got);
        check_eq("skip_to_2", got, 2);
        run_txn(0, 16'h3333, 2, 1'b0, 1'b0, got);
        check_eq("then_3", got, 3);

        // All fetchers request continuously: strict rotation, no starvation.
        for (int j = 0; j < NC; j++) addr[j] = AB'(8'h40 + j);
        valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_txn(int'($urandom_range(0, 3)), DB'($urandom), 0, 1'b0, 1'b0, got);
            check_eq("rr_order", got, order[k]);
            if (got >= 0) begin
                addr[got]  = AB'($urandom);
                valid[got] = 1'b1;
            end
        end

        // Consumer 1 withdraws while the read is pending: one-cycle ready.
        valid   = 4'b0010;
        addr[1] = 8'h77;
        run_txn(3, 16'hBEEF, 0, 1'b1, 1'b0, got);
        check_eq("drop_winner", got, 1);
        tick();
        check_eq("drop_idle", mvalid, 0);

        // Reset during WAITING abandons the read; a late response is ignored.
        valid    = 4'b0001;
        addr[0]  = 8'h99;
        tick();
        check_eq("pre_rst_mvalid", mvalid, 1);
        do_reset();
        mready = 1'b1;
        mdata  = 16'hDEAD;
        tick();
        mready = 1'b0;
        tick();
        check_eq("late_rdy", rdy, 0);
        check_eq("late_mvalid", mvalid, 0);
        check_eq("late_maddr", maddr, 0);
        check_eq("late_terr", terr, 0);
        check_all_data("late_data");

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            for (int j = 0; j < NC; j++) begin
                if (!valid[j] && $urandom_range(0, 3) == 0) begin
                    addr[j]  = AB'($urandom);
                    valid[j] = 1'b1;
                end
            end
            if (valid == '0) begin
                got        = int'($urandom_range(0, NC - 1));
                addr[got]  = AB'($urandom);
                valid[got] = 1'b1;
            end
            run_txn(int'($urandom_range(0, 4)), DB'($urandom), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 5) == 0), 1'b1, got);
        end

`ifdef PROG_MEM_TIMEOUT_EN
        // Silent memory: NOP after eight WAITING cycles and a sticky flag.
        do_reset();
        valid    = 4'b0001;
        addr[0]  = 8'h11;
        run_txn(0, 16'hFFFF, 0, 1'b0, 1'b0, got);
        valid    = 4'b0001;
        addr[0]  = 8'h2A;
        tick();
        check_eq("to_mvalid", mvalid, 1);
        for (int c = 0; c < 7; c++) begin
            tick();
            check_eq("to_wait_rdy", rdy, 0);
        end
        tick();
        check_eq("to_rdy", rdy, 1);
        check_eq("to_nop", rdata[0], 0);
        check_eq("to_flag", terr, 1);
        check_eq("to_mvalid_clr", mvalid, 0);
        valid = '0;
        tick();
        check_eq("to_release", rdy, 0);
        tick();
        check_eq("to_sticky", terr, 1);
        do_reset();
        check_eq("to_rst_clr", terr, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
